// File: rtl/output_rr_arbiter.sv
// rtl/output_rr_arbiter.sv - round-robin output-port arbiter with per-packet lock
//
// Purpose:
//   Arbitrates one output port among NUMBER_CHANNELS input channels. A winner is
//   picked round-robin starting at ptr. The arbiter then holds that grant for the
//   whole packet, until a flit flagged end-of-packet is actually transferred.
//   After each release the arbiter spends one cycle idle, and the channel after the
//   releasing one becomes the highest priority.
//
// Ports:
//   clk   in   clock, all state changes on the rising edge
//   rst   in   synchronous active-high reset
//   req   in   [N] per-channel request for this output
//   rok   in   [N] per-channel input FIFO not empty
//   eop   in   [N] per-channel head flit is end-of-packet
//   wok   in   downstream can accept a flit this cycle
//   gnt   out  [N] registered one-hot grant, zero when idle
//   sel   out  [N] registered one-hot switch select, always equal to gnt
//   rd    out  [N] combinational FIFO pop: gnt & rok & wok
//   busy  out  registered, high while a channel holds the lock

module output_rr_arbiter #(
   parameter int NUMBER_CHANNELS = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUMBER_CHANNELS-1:0] req,
   input  logic [NUMBER_CHANNELS-1:0] rok,
   input  logic [NUMBER_CHANNELS-1:0] eop,
   input  logic                       wok,
   output logic [NUMBER_CHANNELS-1:0] gnt,
   output logic [NUMBER_CHANNELS-1:0] sel,
   output logic [NUMBER_CHANNELS-1:0] rd,
   output logic                       busy
);

   localparam int PW = (NUMBER_CHANNELS > 1) ? $clog2(NUMBER_CHANNELS) : 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [NUMBER_CHANNELS-1:0] gnt_q, gnt_d;
   logic [PW-1:0]              ptr_q, ptr_d;
   logic [PW-1:0]              owner_q, owner_d;
   logic                       busy_q, busy_d;

   logic                       win_found;
   logic [PW-1:0]              win_idx;
   logic                       xfer_eop;
   logic [PW-1:0]              owner_next;

   // Only the granted channel can ever be popped, because rd is masked by gnt.
   assign rd   = gnt_q & rok & {NUMBER_CHANNELS{wok}};
   assign gnt  = gnt_q;
   assign sel  = gnt_q;
   assign busy = busy_q;

   // An end-of-packet flit leaves only when it is actually popped. Because rd is
   // already masked by the grant, eop on non-granted channels is ignored here.
   assign xfer_eop = |(rd & eop);

   // The channel after the owner becomes the highest priority, with wrap to 0.
   assign owner_next = (int'(owner_q) == NUMBER_CHANNELS - 1) ? '0 : owner_q + PW'(1);

   // Rotating priority search: scan ptr, ptr+1, ... modulo N and take the first
   // requester. The index is reduced by one conditional subtract instead of a
   // general modulo, because ptr + off is always below 2*N.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int off = 0; off < NUMBER_CHANNELS; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= NUMBER_CHANNELS) begin
            idx = idx - NUMBER_CHANNELS;
         end
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               owner_d        = win_idx;
               state_d        = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            // The lock ignores req entirely. Only a popped eop flit ends it.
            if (xfer_eop) begin
               gnt_d   = '0;
               ptr_d   = owner_next;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_output_rr_arbiter.sv
// tb/tb_output_rr_arbiter.sv - self-checking bench for output_rr_arbiter

module tb_output_rr_arbiter;

   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req, rok, eop;
   logic         wok;
   logic [N-1:0] gnt, sel, rd;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [N-1:0] sb_q[$];
   logic [N-1:0] prev_gnt = '0;

   output_rr_arbiter #(.NUMBER_CHANNELS(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .rok  (rok),
      .eop  (eop),
      .wok  (wok),
      .gnt  (gnt),
      .sel  (sel),
      .rd   (rd),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: each new grant is compared with the next expected
   // grant. Structural invariants are checked on every falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != '0 && prev_gnt == '0) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_grant", 32'(gnt), 32'h0);
            end else begin
               chk("sb_grant", 32'(gnt), 32'(sb_q.pop_front()));
            end
         end
         chk("inv_onehot", 32'($countones(gnt) <= 1), 32'h1);
         chk("inv_busy", 32'(busy), 32'(gnt != '0));
         chk("inv_sel", 32'(sel), 32'(gnt));
         chk("inv_rd", 32'(rd), 32'(gnt & rok & {N{wok}}));
      end
      prev_gnt = gnt;
   end

   logic [N-1:0] wrap_seq [6];

   initial begin
      wrap_seq[0] = 5'b00001; wrap_seq[1] = 5'b00010; wrap_seq[2] = 5'b00100;
      wrap_seq[3] = 5'b01000; wrap_seq[4] = 5'b10000; wrap_seq[5] = 5'b00001;

      rst = 1'b1; req = '0; rok = '0; eop = '0; wok = 1'b0;
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rd", 32'(rd), 32'h0);

      // First grant after reset, then a three-flit packet with wok toggling.
      rst = 1'b0; req = 5'b10100; rok = 5'b10100; eop = '0; wok = 1'b1;
      sb_q.push_back(5'b00100);
      tick();
      chk("g2_gnt", 32'(gnt), 32'h04);
      chk("g2_sel", 32'(sel), 32'h04);
      chk("g2_busy", 32'(busy), 32'h1);
      chk("g2_rd", 32'(rd), 32'h04);
      tick();
      wok = 1'b0; #1;
      chk("pkt_rd_wok0", 32'(rd), 32'h0);
      tick();
      chk("pkt_hold_wok0", 32'(gnt), 32'h04);
      wok = 1'b1; #1;
      chk("pkt_rd_f2", 32'(rd), 32'h04);
      tick();
      eop = 5'b00100; #1;
      chk("pkt_rd_f3", 32'(rd), 32'h04);
      sb_q.push_back(5'b10000);
      tick();
      chk("pkt_release_gnt", 32'(gnt), 32'h0);
      chk("pkt_release_busy", 32'(busy), 32'h0);
      eop = '0;
      tick();
      chk("ptr3_next_grant", 32'(gnt), 32'h10);
      eop = 5'b10000;
      tick();
      chk("rel4_gnt", 32'(gnt), 32'h0);

      // All channels requesting with single-flit packets: grants rotate and wrap.
      req = '1; rok = '1; eop = '1; wok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         sb_q.push_back(wrap_seq[k]);
         tick();
         chk("wrap_grant", 32'(gnt), 32'(wrap_seq[k]));
         tick();
         chk("wrap_idle", 32'(gnt), 32'h0);
      end
      req = '0; eop = '0; rok = '0;

      // Lock holds through req changes and non-granted eop/rok.
      req = 5'b00010; rok = 5'b00010;
      sb_q.push_back(5'b00010);
      tick();
      chk("lock1_gnt", 32'(gnt), 32'h02);
      req = 5'b01000; rok = 5'b01010; eop = 5'b01000;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("lock1_hold", 32'(gnt), 32'h02);
      end
      eop = 5'b00010; #1;
      chk("lock1_rd_eop", 32'(rd), 32'h02);
      sb_q.push_back(5'b01000);
      tick();
      chk("lock1_release", 32'(gnt), 32'h0);
      eop = '0;
      tick();
      chk("ch3_grant", 32'(gnt), 32'h08);
      eop = 5'b01000; rok = 5'b01000;
      tick();
      chk("ch3_release", 32'(gnt), 32'h0);
      req = '0; eop = '0; rok = '0;

      // Reset mid-packet abandons the lock and clears ptr.
      req = 5'b10000; rok = 5'b10000;
      sb_q.push_back(5'b10000);
      tick();
      chk("ch4_grant", 32'(gnt), 32'h10);
      tick();
      chk("ch4_mid", 32'(gnt), 32'h10);
      rst = 1'b1;
      tick();
      chk("midrst_gnt", 32'(gnt), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_sel", 32'(sel), 32'h0);
      rst = 1'b0; req = 5'b10001; rok = 5'b10001;
      sb_q.push_back(5'b00001);
      tick();
      chk("postrst_ptr0", 32'(gnt), 32'h01);
      eop = 5'b00001;
      tick();
      chk("postrst_release", 32'(gnt), 32'h0);
      eop = '0; req = '0; rok = '0;

      // eop without rok, or without wok, must not release.
      req = 5'b00001; rok = 5'b00001;
      sb_q.push_back(5'b00001);
      tick();
      chk("ch0_grant_wrap", 32'(gnt), 32'h01);
      eop = 5'b00001; wok = 1'b0; #1;
      chk("eop_wok0_rd", 32'(rd), 32'h0);
      tick();
      chk("eop_wok0_hold", 32'(gnt), 32'h01);
      wok = 1'b1; rok = '0; #1;
      chk("eop_rok0_rd", 32'(rd), 32'h0);
      tick(); tick();
      chk("eop_rok0_hold", 32'(gnt), 32'h01);
      chk("eop_rok0_busy", 32'(busy), 32'h1);
      rok = 5'b00001; #1;
      chk("eop_rok1_rd", 32'(rd), 32'h01);
      tick();
      chk("eop_rok1_release", 32'(gnt), 32'h0);
      chk("eop_rok1_busy", 32'(busy), 32'h0);
      req = '0; eop = '0;
      tick();
      chk("idle_noreq", 32'(gnt), 32'h0);

      tick();
      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
